// File: rtl/vga_readback.sv
// Pixel readback engine: latches a coordinate from a register and reads that framebuffer pixel.
// Then writes the pixel colour back into a destination register. The optional bounds check is
// enabled by defining VGA_READBACK_BOUNDS_EN.
module vga_readback #(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int RD_LATENCY = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [255:0] registers,
  input  logic [3:0]   coord_select,
  input  logic [3:0]   dest_select,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         fb_rd_en,
  output logic [14:0]  fb_addr,
  input  logic [14:0]  fb_data,
  output logic         reg_we,
  output logic [3:0]   reg_waddr,
  output logic [15:0]  reg_wdata,
  output logic         oob
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CAPTURE,
    S_WB
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_wait_cnt;
  logic [14:0] r_fb_addr;
  logic [3:0]  r_dest;
  logic [3:0]  r_waddr;
  logic [15:0] r_wdata;
  logic        r_oob;

  logic [7:0]  w_base;
  logic [7:0]  w_x;
  logic [6:0]  w_y;
  logic [14:0] w_addr;
  logic        w_oob;

  // Bit 15 of the coordinate word is never selected, so it cannot leak into y.
  assign w_base = {coord_select, 4'd0};
  assign w_x    = registers[w_base +: 8];
  assign w_y    = registers[8'(w_base + 8'd8) +: 7];
  // The address is formed from the start-edge coordinate and held in r_fb_addr.
  // This matches a register-then-multiply order and keeps fb_addr stable outside READ.
  assign w_addr = 15'(w_y) * 15'(SCREEN_W) + 15'(w_x);

`ifdef VGA_READBACK_BOUNDS_EN
  assign w_oob = (32'(w_x) >= 32'(SCREEN_W)) || (32'(w_y) >= 32'(SCREEN_H));
`else
  assign w_oob = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
      r_fb_addr  <= '0;
      r_dest     <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_oob      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_fb_addr <= w_addr;
            r_dest    <= dest_select;
            r_oob     <= w_oob;
          end
        end
        S_READ:  r_wait_cnt <= '0;
        S_WAIT:  r_wait_cnt <= r_wait_cnt + 2'd1;
        S_CAPTURE: begin
          r_waddr <= r_dest;
          r_wdata <= r_oob ? 16'h8000 : {1'b0, fb_data};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next   = r_state;
    busy     = 1'b1;
    done     = 1'b0;
    reg_we   = 1'b0;
    fb_rd_en = 1'b0;
    oob      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_READ;
      end
      S_READ: begin
        fb_rd_en = !r_oob;
        w_next   = (RD_LATENCY <= 1) ? S_CAPTURE : S_WAIT;
      end
      S_WAIT: begin
        if (r_wait_cnt == 2'(RD_LATENCY - 2)) w_next = S_CAPTURE;
      end
      S_CAPTURE: w_next = S_WB;
      S_WB: begin
        done   = 1'b1;
        reg_we = 1'b1;
        oob    = r_oob;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign fb_addr   = r_fb_addr;
  assign reg_waddr = r_waddr;
  assign reg_wdata = r_wdata;

endmodule

// File: doc/vga_readback.md
# vga_readback

Pixel readback engine: the read-side counterpart of the register-to-VGA plot path. On `start`, it takes a packed coordinate word from a selected 16-bit register, reads that pixel's 15-bit colour from the framebuffer's synchronous read port, and writes the colour back into a selected register through the register file's write port. It sits between the 16×16-bit register file and the framebuffer RAM. It lets programs sample screen contents, for example for collision tests or flood fill.

## Interface
Parameters:
- `SCREEN_W`, default 160: pixels per row.
- `SCREEN_H`, default 120: rows.
- `RD_LATENCY`, default 1: framebuffer read latency in cycles; legal values 1..3.

Ports (clock and reset first):
- `clock` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `registers` in 256: flattened register file; register n is `[n*16 +: 16]`.
- `coord_select` in 4: register holding the coordinate (x = bits [7:0], y = bits [14:8], bit 15 ignored).
- `dest_select` in 4: register that receives the result.
- `start` in 1: request; single-cycle or level.
- `busy` out 1: high while a request is in flight.
- `done` out 1: one-cycle pulse, coincident with `reg_we`.
- `fb_rd_en` out 1: framebuffer read strobe.
- `fb_addr` out 15: y*SCREEN_W + x.
- `fb_data` in 15: framebuffer read data, valid RD_LATENCY cycles after `fb_rd_en`.
- `reg_we` out 1: register-file write enable.
- `reg_waddr` out 4: register-file write index.
- `reg_wdata` out 16: register-file write data.
- `oob` out 1: out-of-bounds flag; see Configuration.

## Operation
- FSM states: IDLE → READ → WAIT → CAPTURE → WB → IDLE.
- **IDLE:** `busy`=0. When `start`=1 at an edge:
  - latch x, y from `registers[coord_select*16 +: 16]`;
  - latch `dest_select`;
  - go to READ.
- **READ:** one cycle.
  - `fb_rd_en`=1.
  - `fb_addr` = registered y*SCREEN_W+x, computed in 15 bits with no truncation for legal inputs (max 127*160+255 = 20575).
- **WAIT:** counts RD_LATENCY-1 cycles. When RD_LATENCY=1 it is skipped and READ goes directly to CAPTURE.
- **CAPTURE:** latch `fb_data` into the internal result register.
- **WB:** one cycle.
  - `reg_we`=1, `done`=1.
  - `reg_waddr` = latched dest.
  - `reg_wdata` = {1'b0, result}.
- `start` is ignored in every state other than IDLE, WB included. Requests are neither queued nor merged.
- Changes to `registers`, `coord_select` or `dest_select` after the start edge do not affect the request in flight.
- Writing a result to the same register that supplied the coordinate is legal; the coordinate was already latched.
- `fb_addr` holds its last value outside READ. `reg_waddr` and `reg_wdata` hold their values outside WB. Consumers qualify these with the strobes.

## Timing
- Reset (asynchronous, at any point) forces:
  - state IDLE;
  - `busy`, `done`, `fb_rd_en`, `reg_we`, `oob` = 0;
  - `fb_addr`, `reg_waddr`, `reg_wdata` = 0.
- Reset during a request aborts it and no `reg_we` is issued. The first post-reset edge with `start`=1 is accepted.
- Start accepted at edge E0:
  - `fb_rd_en` high in cycle E0+1;
  - CAPTURE in cycle E0+1+RD_LATENCY;
  - `reg_we`/`done` in cycle E0+2+RD_LATENCY (cycle 3 for the default).
- `busy` is high from E0+1 through the WB cycle inclusive.
- Back-to-back throughput is one request per 3+RD_LATENCY cycles: the next start is accepted at the edge ending the first IDLE cycle after WB.

## Configuration
- `VGA_READBACK_BOUNDS_EN` **defined:**
  - At the start edge, x≥SCREEN_W or y≥SCREEN_H marks the request out of bounds.
  - READ issues no `fb_rd_en`.
  - WB writes 16'h8000.
  - `oob` pulses high together with `done`.
- `VGA_READBACK_BOUNDS_EN` **undefined:**
  - No check is made.
  - The raw y*SCREEN_W+x address is issued.
  - `oob` is tied to 0.

## Test plan
- Reg 2=16'h0A05 (x=5, y=10), dest=7, start pulse, fb returns 15'h1234 → `fb_addr`=1605 with `fb_rd_en` in cycle 1; `reg_we`, `reg_waddr`=7, `reg_wdata`=16'h1234, `done` in cycle 3; `busy` high in cycles 1–3 only.
- Coordinate x=159, y=119 with RD_LATENCY=3 → `fb_addr`=19199; `reg_we` in cycle 5.
- `start` held high continuously → requests complete at cycles 3, 7, 11; `start` during busy never causes a second `fb_rd_en`.
- Coordinate register overwritten one cycle after start → `fb_addr` reflects the original value.
- `reset` asserted in the cycle after `fb_rd_en` → all outputs 0 immediately; no `reg_we` follows.
- With the macro defined, x=200 → no `fb_rd_en`; `reg_wdata`=16'h8000 with `oob`=`done`=1. Without the macro, the same request gives `fb_addr`=y*160+200 and `oob`=0.
